stream_credit_gate: RTL and testbench

- Credit-based admission gate for an AXI-Stream pipeline. It caps the number of beats in flight between its output and a downstream release point.
- Generalises the single-step semaphore:
  - runtime-programmable limit,
  - multi-credit release per cycle,
  - correct net accounting on simultaneous accept/release,
  - sticky underflow detection,
  - registered 2-entry output buffer.
- Sits in front of the rasterizer/texture pipelines. The pipeline tail drives rel_count as beats retire.

---
 rtl/stream_credit_gate_if.sv | 15 +
 rtl/stream_credit_gate.sv | 149 ++++++++++++++
 tb/tb_stream_credit_gate.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_credit_gate_if.sv
// AXI-Stream beat bundle shared by the upstream (slave) and downstream (master)
// sides of stream_credit_gate.
interface stream_credit_gate_if #(
  parameter int STREAM_WIDTH = 32,
  parameter int KEEP_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [STREAM_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0]   tkeep;

  modport master (output tvalid, tlast, tdata, tkeep, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/stream_credit_gate.sv
// Credit-based admission gate: caps beats in flight to a downstream release point,
// with a registered 2-entry output buffer. Define STREAM_CREDIT_GATE_STATS_EN for stall/peak stats.
module stream_credit_gate #(
  parameter  int STREAM_WIDTH = 32,
  parameter  int KEEP_WIDTH   = 1,
  parameter  int MAX_CREDITS  = 128,
  parameter  int REL_W        = 2,
  localparam int CNT_W        = $clog2(MAX_CREDITS + 1)
) (
  input  logic                 aclk,
  input  logic                 reset,
  stream_credit_gate_if.slave  s_axis,
  stream_credit_gate_if.master m_axis,
  input  logic [CNT_W-1:0]     cfg_limit,
  input  logic [REL_W-1:0]     rel_count,
  output logic [CNT_W-1:0]     in_flight,
  output logic                 released,
  output logic                 underflow_err
`ifdef STREAM_CREDIT_GATE_STATS_EN
  ,
  input  logic                 stat_clear,
  output logic [31:0]          stat_stall_cycles,
  output logic [CNT_W-1:0]     stat_peak
`endif
);

  localparam int SUM_W = ((CNT_W > REL_W) ? CNT_W : REL_W) + 1;
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_CREDITS);

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;

  typedef struct packed {
    logic                    last;
    logic [KEEP_WIDTH-1:0]   keep;
    logic [STREAM_WIDTH-1:0] data;
  } beat_t;

  buf_state_e       state_q, state_d;
  beat_t            main_q, skid_q, in_beat;
  logic             load_main_in, load_main_skid, load_skid_in;
  logic             buf_not_full, acc, pop;
  logic [CNT_W-1:0] lim_eff, in_flight_q, in_flight_d;
  logic             released_q, underflow_q, underflow_d;
  logic [SUM_W-1:0] sum, rel_ext;

  assign lim_eff      = (cfg_limit > MAX_LIM) ? MAX_LIM : cfg_limit;
  assign buf_not_full = (state_q != BUF_FULL);
  // Ready depends only on registered state and cfg_limit, never on m_axis.tready or rel_count.
  assign s_axis.tready = buf_not_full && (in_flight_q < lim_eff);
  assign acc     = s_axis.tvalid && s_axis.tready;
  assign pop     = m_axis.tvalid && m_axis.tready;
  assign in_beat = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  assign m_axis.tvalid = (state_q != BUF_EMPTY);
  assign m_axis.tdata  = main_q.data;
  assign m_axis.tkeep  = main_q.keep;
  assign m_axis.tlast  = main_q.last;

  // NOTE: every variable written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    unique case (state_q)
      BUF_EMPTY: if (acc) begin
        state_d      = BUF_ONE;
        load_main_in = 1'b1;
      end
      BUF_ONE: begin
        if (acc && pop) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_d      = BUF_FULL;
          load_skid_in = 1'b1;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: if (pop) begin
        state_d        = BUF_ONE;
        load_main_skid = 1'b1;
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      // NOTE: the beat registers are reset because the outputs must read zero after reset.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in)        main_q <= in_beat;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_beat;
    end
  end

  // Net accounting in a widened domain so accept and release never wrap.
  always_comb begin
    sum         = SUM_W'(in_flight_q) + SUM_W'(acc);
    rel_ext     = SUM_W'(rel_count);
    underflow_d = underflow_q;
    if (rel_ext <= sum) begin
      in_flight_d = CNT_W'(sum - rel_ext);
    end else begin
      in_flight_d = '0;
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      in_flight_q <= '0;
      released_q  <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      released_q  <= (in_flight_d == '0);
      underflow_q <= underflow_d;
    end
  end

  assign in_flight     = in_flight_q;
  assign released      = released_q;
  assign underflow_err = underflow_q;

`ifdef STREAM_CREDIT_GATE_STATS_EN
  logic credit_stall;

  // Only credit exhaustion counts as a stall; a full buffer alone does not.
  assign credit_stall = s_axis.tvalid && (in_flight_q >= lim_eff);

  always_ff @(posedge aclk) begin
    if (reset || stat_clear) begin
      stat_stall_cycles <= '0;
      stat_peak         <= '0;
    end else begin
      if (credit_stall && (stat_stall_cycles != '1)) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (in_flight_d > stat_peak) stat_peak <= in_flight_d;
    end
  end
`endif

endmodule

// File: tb/tb_stream_credit_gate.sv
// Self-checking bench for stream_credit_gate: directed scenarios plus random traffic,
// scored against a queue-based credit/buffer reference model.
module tb_stream_credit_gate;
  localparam int SW   = 32;
  localparam int KW   = 1;
  localparam int MAXC = 128;
  localparam int RW   = 2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct {
    logic [SW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          reset;
  logic [CW-1:0] cfg_limit;
  logic [RW-1:0] rel_count;
  logic [CW-1:0] in_flight;
  logic          released;
  logic          underflow_err;
`ifdef STREAM_CREDIT_GATE_STATS_EN
  logic          stat_clear;
  logic [31:0]   stat_stall_cycles;
  logic [CW-1:0] stat_peak;
`endif

  stream_credit_gate_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) s_if ();
  stream_credit_gate_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) m_if ();

  stream_credit_gate #(
    .STREAM_WIDTH(SW), .KEEP_WIDTH(KW), .MAX_CREDITS(MAXC), .REL_W(RW)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .cfg_limit     (cfg_limit),
    .rel_count     (rel_count),
    .in_flight     (in_flight),
    .released      (released),
    .underflow_err (underflow_err)
`ifdef STREAM_CREDIT_GATE_STATS_EN
    ,
    .stat_clear        (stat_clear),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_peak         (stat_peak)
`endif
  );

  always #5 aclk = ~aclk;

  // Reference model: credit count, buffer occupancy and the ordered list of expected beats.
  int    mdl_if   = 0;
  int    mdl_occ  = 0;
  bit    mdl_uf   = 1'b0;
  beat_t exp_q[$];
  int    n_acc    = 0;
  bit    last_acc = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: predict ready, advance the model at the edge, then compare status.
  task automatic step();
    int lim;
    int sum;
    bit exp_rdy;
    bit acc;
    bit pop;
    #2;
    lim     = (int'(cfg_limit) > MAXC) ? MAXC : int'(cfg_limit);
    exp_rdy = (mdl_occ < 2) && (mdl_if < lim);
    check("s_tready", s_if.tready, exp_rdy);
    acc = s_if.tvalid && exp_rdy;
    pop = (mdl_occ > 0) && m_if.tready;
    @(posedge aclk);
    last_acc = 1'b0;
    if (reset) begin
      mdl_if  = 0;
      mdl_occ = 0;
      mdl_uf  = 1'b0;
      exp_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back('{s_if.tdata, s_if.tkeep, s_if.tlast});
        n_acc++;
        last_acc = 1'b1;
      end
      mdl_occ += int'(acc) - int'(pop);
      sum = mdl_if + int'(acc);
      if (int'(rel_count) > sum) begin
        mdl_if = 0;
        mdl_uf = 1'b1;
      end else begin
        mdl_if = sum - int'(rel_count);
      end
    end
    #1;
    check("in_flight", in_flight, mdl_if);
    check("released", released, (mdl_if == 0));
    check("underflow_err", underflow_err, mdl_uf);
    check("m_tvalid", m_if.tvalid, (mdl_occ > 0));
  endtask

  task automatic drive(input bit v, input logic [SW-1:0] d, input bit l, input bit mr, input int rel);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tkeep  = d[KW-1:0];
    s_if.tlast  = l;
    m_if.tready = mr;
    rel_count   = RW'(rel);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 0);
    reset = 1'b0;
  endtask

  // Monitor: whenever the DUT presents a beat it must match the oldest expected one.
  always @(negedge aclk) begin
    if (!reset && m_if.tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("m_unexpected_beat", 1, 0);
      end else begin
        check("m_tdata", m_if.tdata, exp_q[0].data);
        check("m_tkeep", m_if.tkeep, exp_q[0].keep);
        check("m_tlast", m_if.tlast, exp_q[0].last);
        if (m_if.tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int n0;
    reset       = 1'b1;
    cfg_limit   = '0;
    rel_count   = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
`ifdef STREAM_CREDIT_GATE_STATS_EN
    stat_clear  = 1'b0;
`endif
    repeat (2) @(posedge aclk);
    #1;
    check("rst_in_flight", in_flight, 0);
    check("rst_released", released, 1);
    check("rst_underflow", underflow_err, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    reset = 1'b0;

    // Fill to the limit: only 4 of 10 offered beats get in.
    cfg_limit = CW'(4);
    cur = 0;
    n0  = n_acc;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + cur, (cur % 2) == 1, 1'b1, 0);
      if (last_acc) cur++;
    end
    check("fill_accepted", n_acc - n0, 4);
    check("fill_in_flight", in_flight, 4);
    check("fill_tready", s_if.tready, 0);

    // Multi-credit release, then top up again.
    drive(1'b0, '0, 1'b0, 1'b1, 3);
    check("rel3_in_flight", in_flight, 1);
    n0 = n_acc;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h200 + cur, 1'b0, 1'b1, 0);
      if (last_acc) cur++;
    end
    check("refill_accepted", n_acc - n0, 3);
    check("refill_in_flight", in_flight, 4);

    // Simultaneous accept and release; then an over-release.
    do_reset();
    cfg_limit = CW'(128);
    drive(1'b1, 32'h300, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h301, 1'b0, 1'b1, 0);
    check("sim_pre", in_flight, 2);
    drive(1'b1, 32'h302, 1'b0, 1'b1, 1);
    check("sim_net_zero", in_flight, 2);
    drive(1'b1, 32'h303, 1'b1, 1'b1, 3);
    check("sim_drain", in_flight, 0);
    drive(1'b1, 32'h304, 1'b1, 1'b1, 3);
    check("under_in_flight", in_flight, 0);
    check("under_flag", underflow_err, 1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b1, 0);
    check("under_sticky", underflow_err, 1);
    check("under_released", released, 1);

    // Backpressure: two beats buffer, third waits, order and tlast kept.
    do_reset();
    cfg_limit = CW'(128);
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      if (cur < 3) drive(1'b1, 32'hA0 + cur, cur == 2, i >= 4, 0);
      else         drive(1'b0, '0, 1'b0, i >= 4, 0);
      if (last_acc) cur++;
      if (i == 2) check("bp_tready_low", s_if.tready, 0);
    end
    check("bp_all_accepted", cur, 3);

    // Lower the limit below in_flight, drain by one per cycle, then reset mid-stream.
    do_reset();
    cfg_limit = CW'(128);
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h400 + i, 1'b0, 1'b1, 0);
    check("lim_pre", in_flight, 6);
    cfg_limit = CW'(3);
    n0 = n_acc;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h410 + i, 1'b0, 1'b1, 1);
    check("lim_no_accept", n_acc - n0, 0);
    check("lim_in_flight", in_flight, 3);
    drive(1'b1, 32'h420, 1'b0, 1'b1, 1);
    drive(1'b1, 32'h421, 1'b0, 1'b1, 1);
    check("lim_resume", n_acc - n0, 1);
    reset = 1'b1;
    drive(1'b1, 32'h430, 1'b0, 1'b0, 0);
    reset = 1'b0;
    check("midrst_in_flight", in_flight, 0);
    check("midrst_released", released, 1);
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_underflow", underflow_err, 0);

`ifdef STREAM_CREDIT_GATE_STATS_EN
    do_reset();
    cfg_limit = CW'(1);
    drive(1'b1, 32'h500, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h501, 1'b0, 1'b1, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 0);
    check("stat_stall", stat_stall_cycles, 5);
    check("stat_peak", stat_peak, 1);
    stat_clear = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1, 0);
    stat_clear = 1'b0;
    check("stat_clr_stall", stat_stall_cycles, 0);
    check("stat_clr_peak", stat_peak, 0);
`endif

    // Random traffic.
    do_reset();
    cfg_limit = CW'(8);
    for (int i = 0; i < 1500; i++) begin
      int rel;
      if (i % 100 == 0) begin
        case ($urandom_range(0, 4))
          0:       cfg_limit = '0;
          1:       cfg_limit = CW'($urandom_range(129, 255));
          default: cfg_limit = CW'($urandom_range(1, 12));
        endcase
      end
      rel = 0;
      if (mdl_if > 0 && ($urandom_range(0, 2) == 0)) rel = $urandom_range(1, 3);
      if ($urandom_range(0, 60) == 0) rel = 3;
      reset = ($urandom_range(0, 400) == 0);
      drive($urandom_range(0, 3) != 0, SW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, rel);
      reset = 1'b0;
    end

    // Everything accepted must eventually appear at the output.
    cfg_limit = '0;
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1, 0);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
